// File: rtl/vga_rd_ctrl_pkg.sv
// Shared types, derived raster constants and sizing helpers for the VGA
// frame-buffer read controller.
package vga_rd_ctrl_pkg;

    localparam int RGB_W = 24;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PREFILL = 2'd1,
        ST_RUN     = 2'd2
    } rd_state_e;

    // Registered raster strobes, all aligned with the displayed pixel.
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic last;
    } vga_tim_t;

    // Default 1080p60 raster.
    localparam int H_SYNC_DEF  = 44;
    localparam int H_BACK_DEF  = 148;
    localparam int H_VALID_DEF = 1920;
    localparam int H_FRONT_DEF = 88;
    localparam int V_SYNC_DEF  = 5;
    localparam int V_BACK_DEF  = 36;
    localparam int V_VALID_DEF = 1080;
    localparam int V_FRONT_DEF = 4;

    function automatic int axis_total(input int sync, input int back,
                                      input int valid, input int front);
        return sync + back + valid + front;
    endfunction

    function automatic int act_beg(input int sync, input int back);
        return sync + back;
    endfunction

    function automatic int act_end(input int sync, input int back, input int valid);
        return sync + back + valid - 1;
    endfunction

    function automatic int cnt_width(input int total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

    localparam int H_TOTAL_DEF   = axis_total(H_SYNC_DEF, H_BACK_DEF, H_VALID_DEF, H_FRONT_DEF);
    localparam int V_TOTAL_DEF   = axis_total(V_SYNC_DEF, V_BACK_DEF, V_VALID_DEF, V_FRONT_DEF);
    localparam int H_ACT_BEG_DEF = act_beg(H_SYNC_DEF, H_BACK_DEF);
    localparam int H_ACT_END_DEF = act_end(H_SYNC_DEF, H_BACK_DEF, H_VALID_DEF);
    localparam int V_ACT_BEG_DEF = act_beg(V_SYNC_DEF, V_BACK_DEF);
    localparam int V_ACT_END_DEF = act_end(V_SYNC_DEF, V_BACK_DEF, V_VALID_DEF);

endpackage

// File: rtl/vga_rd_ctrl_if.sv
// Bundle between the read controller, the read FIFO / SDRAM controller and the
// video PHY.
interface vga_rd_ctrl_if;
    import vga_rd_ctrl_pkg::*;

    // rd_fifo_rd_req is a blind pop: no ready is returned, and the word shows
    // up on rd_fifo_rd_data exactly one clock after the request cycle.
    logic             vga_count_en;
    logic [RGB_W-1:0] rd_fifo_rd_data;
    logic             rd_fifo_rd_req;
    logic             read_valid;
    logic             rd_rst;
    logic             vga_hs;
    logic             vga_vs;
    logic             vga_de;
    logic [RGB_W-1:0] vga_rgb;
    logic             frame_done;
    rd_state_e        dbg_state;

    modport master (
        input  vga_count_en,
        input  rd_fifo_rd_data,
        output rd_fifo_rd_req,
        output read_valid,
        output rd_rst,
        output vga_hs,
        output vga_vs,
        output vga_de,
        output vga_rgb,
        output frame_done,
        output dbg_state
    );

    modport slave (
        output vga_count_en,
        output rd_fifo_rd_data,
        input  rd_fifo_rd_req,
        input  read_valid,
        input  rd_rst,
        input  vga_hs,
        input  vga_vs,
        input  vga_de,
        input  vga_rgb,
        input  frame_done,
        input  dbg_state
    );

endinterface

// File: rtl/vga_rd_ctrl_timing.sv
// Free-running raster counters with the early de strobe and the registered
// sync/de/last-pixel strobes that lag the counters by one clock.
module vga_timing_gen
    import vga_rd_ctrl_pkg::*;
#(
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BACK   = H_BACK_DEF,
    parameter int H_VALID  = H_VALID_DEF,
    parameter int H_FRONT  = H_FRONT_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BACK   = V_BACK_DEF,
    parameter int V_VALID  = V_VALID_DEF,
    parameter int V_FRONT  = V_FRONT_DEF,
    parameter int SYNC_POL = 1
) (
    input  logic     sys_clk,
    input  logic     sys_rst_n,
    output logic     de_pre_o,
    output logic     frame_start_o,
    output vga_tim_t tim_o
);

    localparam int H_TOTAL   = axis_total(H_SYNC, H_BACK, H_VALID, H_FRONT);
    localparam int V_TOTAL   = axis_total(V_SYNC, V_BACK, V_VALID, V_FRONT);
    localparam int H_ACT_BEG = act_beg(H_SYNC, H_BACK);
    localparam int H_ACT_END = act_end(H_SYNC, H_BACK, H_VALID);
    localparam int V_ACT_BEG = act_beg(V_SYNC, V_BACK);
    localparam int V_ACT_END = act_end(V_SYNC, V_BACK, V_VALID);
    localparam int HW        = cnt_width(H_TOTAL);
    localparam int VW        = cnt_width(V_TOTAL);

    // Level a sync output sits at outside its pulse.
    localparam logic SYNC_IDLE = (SYNC_POL != 0) ? 1'b0 : 1'b1;

    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic          h_wrap, v_wrap;
    logic          hs_pre, vs_pre, h_act, v_act, last_pre;
    vga_tim_t      tim_q;

    assign h_wrap = (h_cnt_q == HW'(H_TOTAL - 1));
    assign v_wrap = (v_cnt_q == VW'(V_TOTAL - 1));

    always_comb begin
        h_cnt_d = h_wrap ? '0 : h_cnt_q + HW'(1);
        v_cnt_d = v_cnt_q;
        if (h_wrap) begin
            v_cnt_d = v_wrap ? '0 : v_cnt_q + VW'(1);
        end
    end

    assign hs_pre   = (h_cnt_q < HW'(H_SYNC));
    assign vs_pre   = (v_cnt_q < VW'(V_SYNC));
    assign h_act    = (h_cnt_q >= HW'(H_ACT_BEG)) && (h_cnt_q <= HW'(H_ACT_END));
    assign v_act    = (v_cnt_q >= VW'(V_ACT_BEG)) && (v_cnt_q <= VW'(V_ACT_END));
    assign last_pre = (h_cnt_q == HW'(H_ACT_END)) && (v_cnt_q == VW'(V_ACT_END));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            h_cnt_q    <= '0;
            v_cnt_q    <= '0;
            tim_q.hs   <= SYNC_IDLE;
            tim_q.vs   <= SYNC_IDLE;
            tim_q.de   <= 1'b0;
            tim_q.last <= 1'b0;
        end else begin
            h_cnt_q    <= h_cnt_d;
            v_cnt_q    <= v_cnt_d;
            tim_q.hs   <= hs_pre ^ SYNC_IDLE;
            tim_q.vs   <= vs_pre ^ SYNC_IDLE;
            tim_q.de   <= h_act & v_act;
            tim_q.last <= last_pre;
        end
    end

    assign de_pre_o      = h_act & v_act;
    assign frame_start_o = (h_cnt_q == '0) && (v_cnt_q == '0);
    assign tim_o         = tim_q;

endmodule

// File: rtl/vga_rd_ctrl.sv
// Display-side consumer of the SDRAM frame-buffer read FIFO: gates SDRAM
// reads, pops pixels one clock ahead of de and muxes them onto the video bus.
module vga_rd_ctrl
    import vga_rd_ctrl_pkg::*;
#(
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BACK   = H_BACK_DEF,
    parameter int H_VALID  = H_VALID_DEF,
    parameter int H_FRONT  = H_FRONT_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BACK   = V_BACK_DEF,
    parameter int V_VALID  = V_VALID_DEF,
    parameter int V_FRONT  = V_FRONT_DEF,
    parameter int SYNC_POL = 1
) (
    input logic           sys_clk,
    input logic           sys_rst_n,
    vga_rd_ctrl_if.master bus
);

    logic      de_pre;
    logic      frame_start;
    vga_tim_t  tim;
    rd_state_e state_q;
    logic      read_valid_q;
    logic      run_q;

    vga_timing_gen #(
        .H_SYNC  (H_SYNC),
        .H_BACK  (H_BACK),
        .H_VALID (H_VALID),
        .H_FRONT (H_FRONT),
        .V_SYNC  (V_SYNC),
        .V_BACK  (V_BACK),
        .V_VALID (V_VALID),
        .V_FRONT (V_FRONT),
        .SYNC_POL(SYNC_POL)
    ) u_timing (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .de_pre_o     (de_pre),
        .frame_start_o(frame_start),
        .tim_o        (tim)
    );

    // Dropping vga_count_en wins over every other transition. PREFILL only
    // leaves at the (0,0) raster position so a frame is never shown partially.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= ST_IDLE;
            read_valid_q <= 1'b0;
            run_q        <= 1'b0;
        end else begin
            run_q <= (state_q == ST_RUN);
            case (state_q)
                ST_IDLE: begin
                    if (bus.vga_count_en) begin
                        state_q      <= ST_PREFILL;
                        read_valid_q <= 1'b1;
                    end
                end
                ST_PREFILL: begin
                    if (!bus.vga_count_en) begin
                        state_q      <= ST_IDLE;
                        read_valid_q <= 1'b0;
                    end else if (frame_start) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!bus.vga_count_en) begin
                        state_q      <= ST_IDLE;
                        read_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    read_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // rd_rst marks the IDLE->PREFILL cycle itself so the SDRAM read address
    // is rewound before any prefill traffic.
    assign bus.rd_rst         = (state_q == ST_IDLE) & bus.vga_count_en;
    assign bus.read_valid     = read_valid_q;
    assign bus.rd_fifo_rd_req = de_pre & (state_q == ST_RUN);

    assign bus.vga_hs     = tim.hs;
    assign bus.vga_vs     = tim.vs;
    assign bus.vga_de     = tim.de;
    assign bus.vga_rgb    = (tim.de & run_q) ? bus.rd_fifo_rd_data : '0;
    assign bus.frame_done = tim.de & run_q & tim.last;
    assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_vga_rd_ctrl.sv
// Randomized bench for vga_rd_ctrl on a reduced raster, checked every cycle
// against a frame-index arithmetic model of the display rules.
module tb_vga_rd_ctrl;

    localparam int HS = 4, HB = 4, HV = 8, HF = 4;
    localparam int VS = 1, VB = 1, VV = 4, VF = 1;
    localparam int HT = HS + HB + HV + HF;
    localparam int VT = VS + VB + VV + VF;
    localparam int FT = HT * VT;
    localparam int HA_BEG = HS + HB;
    localparam int HA_END = HS + HB + HV - 1;
    localparam int VA_BEG = VS + VB;
    localparam int VA_END = VS + VB + VV - 1;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;

    vga_rd_ctrl_if bus ();

    vga_rd_ctrl #(
        .H_SYNC(HS), .H_BACK(HB), .H_VALID(HV), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_VALID(VV), .V_FRONT(VF),
        .SYNC_POL(1)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .bus      (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n;          // cycles since reset release
    int          sess;       // cycle where the current enable run began, -1 if none
    int          rd_cnt;     // FIFO model word counter
    int          frames_shown;
    bit          prev_run;
    bit          rand_data;
    logic [23:0] fifo_out;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, n, act, exp);
        end
    endtask

    function automatic bit de_pre_at(input int k);
        int h;
        int v;
        h = k % HT;
        v = (k / HT) % VT;
        return (h >= HA_BEG) && (h <= HA_END) && (v >= VA_BEG) && (v <= VA_END);
    endfunction

    function automatic bit last_at(input int k);
        return ((k % HT) == HA_END) && (((k / HT) % VT) == VA_END);
    endfunction

    // Pixels stream from the cycle after the first frame start that follows
    // the cycle in which the enable run began.
    function automatic bit running_at(input int k, input int s);
        int fs;
        if (s < 0) return 1'b0;
        fs = ((s + FT) / FT) * FT;
        return k >= fs + 1;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_hs"}, bus.vga_hs, 0);
        check_eq({tag, "_vs"}, bus.vga_vs, 0);
        check_eq({tag, "_de"}, bus.vga_de, 0);
        check_eq({tag, "_rd_req"}, bus.rd_fifo_rd_req, 0);
        check_eq({tag, "_read_valid"}, bus.read_valid, 0);
        check_eq({tag, "_rd_rst"}, bus.rd_rst, 0);
        check_eq({tag, "_rgb"}, bus.vga_rgb, 0);
        check_eq({tag, "_frame_done"}, bus.frame_done, 0);
    endtask

    task automatic run_cycle(input bit en);
        bit          run_now, exp_req, exp_de, exp_rst, exp_fd, req_seen, rst_seen;
        logic [23:0] exp_rgb;
        bus.vga_count_en    = en;
        bus.rd_fifo_rd_data = fifo_out;
        run_now = running_at(n, sess);
        exp_req = de_pre_at(n) && run_now;
        exp_de  = (n > 0) && de_pre_at(n - 1);
        exp_rst = (sess < 0) && en;
        exp_rgb = (exp_de && prev_run) ? fifo_out : 24'd0;
        exp_fd  = exp_de && prev_run && last_at(n - 1);
        @(negedge sys_clk);
        check_eq("hs", bus.vga_hs, (n > 0) && (((n - 1) % HT) < HS));
        check_eq("vs", bus.vga_vs, (n > 0) && ((((n - 1) / HT) % VT) < VS));
        check_eq("de", bus.vga_de, exp_de);
        check_eq("rd_req", bus.rd_fifo_rd_req, exp_req);
        check_eq("read_valid", bus.read_valid, sess >= 0);
        check_eq("rd_rst", bus.rd_rst, exp_rst);
        check_eq("rgb", bus.vga_rgb, exp_rgb);
        check_eq("frame_done", bus.frame_done, exp_fd);
        if (exp_fd && !rand_data) check_eq("frame_done_rgb", bus.vga_rgb, HV * VV * (frames_shown + 1));
        if (exp_fd) frames_shown++;
        req_seen = bus.rd_fifo_rd_req;
        rst_seen = bus.rd_rst;
        @(posedge sys_clk);
        #1;
        if (rst_seen) begin
            rd_cnt       = 0;
            frames_shown = 0;
        end
        if (req_seen) begin
            rd_cnt++;
            fifo_out = rand_data ? 24'($urandom) : 24'(rd_cnt);
        end
        prev_run = run_now;
        if (en) begin
            if (sess < 0) sess = n;
        end else begin
            sess = -1;
        end
        n++;
    endtask

    task automatic restart_model();
        n        = 0;
        sess     = -1;
        prev_run = 1'b0;
    endtask

    initial begin
        bit en_r;
        bus.vga_count_en    = 1'b0;
        bus.rd_fifo_rd_data = '0;
        fifo_out     = '0;
        rd_cnt       = 0;
        frames_shown = 0;
        rand_data    = 1'b0;
        restart_model();

        repeat (3) @(posedge sys_clk);
        #1;
        check_reset_outputs("reset");
        sys_rst_n = 1'b1;

        // Disabled: raster only, no reads.
        repeat (2 * FT) run_cycle(1'b0);

        // Enable mid-frame at line 3; display must wait for the next frame.
        while (((n / HT) % VT) != 3) run_cycle(1'b0);
        repeat (2 * FT + 40) run_cycle(1'b1);

        // Drop enable on the third active pixel of the first active line.
        while (!((n % HT) == HA_BEG + 2 && ((n / HT) % VT) == VA_BEG)) run_cycle(1'b1);
        repeat (30) run_cycle(1'b0);

        // Re-enable: fresh rd_rst, resumes at next frame start.
        repeat (2 * FT + 10) run_cycle(1'b1);

        // Random enable toggling with random pixel data.
        rand_data = 1'b1;
        en_r      = 1'b1;
        repeat (1500) begin
            if ($urandom_range(0, 119) == 0) en_r = ~en_r;
            run_cycle(en_r);
        end
        rand_data = 1'b0;
        repeat (5) run_cycle(1'b0);

        // Asynchronous reset in the middle of a streamed active line.
        repeat (FT + 20) run_cycle(1'b1);
        while ((n % HT) != HA_BEG + 3 || !de_pre_at(n)) run_cycle(1'b1);
        bus.vga_count_en = 1'b0;
        sys_rst_n        = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        repeat (2) @(posedge sys_clk);
        #1;
        check_reset_outputs("held_rst");
        sys_rst_n = 1'b1;
        restart_model();
        repeat (FT + 7) run_cycle(1'b0);
        repeat (2 * FT + 5) run_cycle(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
